mux2x1_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 2:1 data mux between two requesters.
//  - Sequences the mux select from a 3-state FSM and returns per-requester grants.
//  - Drives a single downstream valid/ready channel.
//  - Grant is held for a bounded burst (MAX_BEATS accepted beats), then rotates if the other side waits.
//  - Sits between two producer ports and one shared consumer port in the lab datapath.

---
 rtl/mux2x1_rr_arbiter_pkg.sv | 14 +
 rtl/mux2x1_rr_arbiter_rr2_pick.sv | 14 +
 rtl/mux2x1_rr_arbiter.sv | 95 +++++++++
 tb/tb_mux2x1_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2x1_rr_arbiter_pkg.sv
// Shared types and defaults for the 2:1 round-robin mux arbiter.
// State encodings are fixed so grants decode directly from state bits.
package mux2x1_rr_arbiter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

endpackage

// File: rtl/mux2x1_rr_arbiter_rr2_pick.sv
// Two-way round-robin pick: on a tie the side that was not served last wins.
// winner=1 selects requester 1.
module rr2_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  assign any    = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two requesters,
// with a bounded burst per grant and a single valid/ready output channel.
module mux2x1_rr_arbiter
  import mux2x1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy
);

  localparam int CW = $clog2(MAX_BEATS) + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;

  logic sel, mine, xfer, quota;
  logic pick_last, winner, any;

  assign sel      = (state_q == ST_G1);
  assign gnt0     = (state_q == ST_G0);
  assign gnt1     = sel;
  assign dout     = sel ? din1 : din0;
  assign dout_vld = (gnt0 & req0) | (gnt1 & req1);
  assign xfer     = dout_vld & dout_rdy;
  assign mine     = sel ? req1 : req0;
  assign quota    = (cnt_q == CW'(MAX_BEATS - 1));

  // While granted, bias the tie toward the other side so one
  // picker serves both the idle choice and the rotation choice.
  always_comb begin
    pick_last = last_q;
    unique case (1'b1)
      gnt0:    pick_last = 1'b0;
      gnt1:    pick_last = 1'b1;
      default: pick_last = last_q;
    endcase
  end

  rr2_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (pick_last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any)
          state_d = winner ? ST_G1 : ST_G0;
      end
      ST_G0, ST_G1: begin
        if (!mine || (xfer && quota))
          state_d = any ? (winner ? ST_G1 : ST_G0)
                        : ST_IDLE;
        if (state_d != state_q) begin
          cnt_d  = '0;
          last_d = sel;
        end else if (xfer) begin
          cnt_d = quota ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Bench for mux2x1_rr_arbiter: directed scenarios plus random traffic,
// all checked against an owner/beat-count reference model.
module tb_mux2x1_rr_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] din0, din1;
  logic         gnt0, gnt1;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         dout_rdy;

  int n_chk = 0;
  int n_err = 0;

  // reference model: owner -1 idle, 0/1 granted side
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = 1;
  bit m_x0, m_x1;

  always #5 clk = ~clk;

  mux2x1_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .din0     (din0),
    .din1     (din1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_vld();
    return (m_owner == 0 && req0) || (m_owner == 1 && req1);
  endfunction

  task automatic drive(input logic r, input logic q0,
                       input logic q1, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rdy);
    rst = r; req0 = q0; req1 = q1;
    din0 = a; din1 = b; dout_rdy = rdy;
    #1;
    chk("gnt0", gnt0, m_owner == 0);
    chk("gnt1", gnt1, m_owner == 1);
    chk("vld", dout_vld, m_vld());
    if (m_vld())
      chk("dout", dout, (m_owner == 1) ? din1 : din0);
  endtask

  // advance model by one clock from the currently driven inputs
  task automatic tick();
    bit mine, other, xf;
    m_x0 = (m_owner == 0) && req0 && dout_rdy;
    m_x1 = (m_owner == 1) && req1 && dout_rdy;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (req0 && req1) m_owner = 1 - m_last;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
    end else begin
      mine  = (m_owner == 0) ? req0 : req1;
      other = (m_owner == 0) ? req1 : req0;
      xf    = mine && dout_rdy;
      if (!mine) begin
        m_last  = m_owner;
        m_owner = other ? 1 - m_owner : -1;
        m_beats = 0;
      end else if (xf) begin
        m_beats++;
        if (m_beats == MB) begin
          m_beats = 0;
          if (other) begin
            m_last  = m_owner;
            m_owner = 1 - m_owner;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 1);
    tick();
  endtask

  initial begin
    bit p0, p1;
    int pq, pr;
    logic [W-1:0] d0, d1;

    rst = 1; req0 = 0; req1 = 0;
    din0 = 0; din1 = 0; dout_rdy = 1;
    @(posedge clk);
    @(negedge clk);

    // reset state and single requester latency
    drive(0, 1, 0, 8'h11, 8'h22, 1);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_vld", dout_vld, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 8'h30 + W'(k), 8'h22, 1);
      chk("t1_gnt0", gnt0, 1);
      chk("t1_gnt1", gnt1, 0);
      chk("t1_dout", dout, 8'h30 + k);
      tick();
    end

    // both requesting: 4-beat bursts alternate, no gap
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      drive(0, 1, 1, 8'hA0 + W'(k), 8'hB0 + W'(k), 1);
      if (k == 0) begin
        chk("t2_idle", {gnt1, gnt0}, 2'b00);
      end else begin
        chk("t2_gnt0", gnt0, ((k - 1) / 4) % 2 == 0);
        chk("t2_gnt1", gnt1, ((k - 1) / 4) % 2 == 1);
      end
      tick();
    end

    // stall ten cycles, then exactly four beats before switching
    do_reset();
    for (int k = 0; k <= 15; k++) begin
      drive(0, 1, 1, 8'h40, 8'h50, k > 10);
      if (k >= 1 && k <= 14) chk("t3_hold", gnt0, 1);
      if (k == 15) chk("t3_sw", gnt1, 1);
      tick();
    end

    // req0 drops after two beats, then tie goes to side 1
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      drive(0, k < 3 || k >= 4, k >= 4, 8'h61, 8'h62, 1);
      if (k == 3) chk("t4_drop_vld", dout_vld, 0);
      if (k == 4) chk("t4_idle", {gnt1, gnt0, dout_vld}, 3'b000);
      if (k == 5) chk("t4_g1", gnt1, 1);
      tick();
    end

    // reset in the middle of a side-1 burst
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      drive(k == 3, k >= 3, 1, 8'h71, 8'h72, 1);
      if (k == 3) chk("t5_g1", gnt1, 1);
      if (k == 4) chk("t5_idle", {gnt1, gnt0, dout_vld}, 3'b000);
      if (k == 5) chk("t5_g0", gnt0, 1);
      tick();
    end

    // lone requester keeps the grant across quota wraps
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      drive(0, 1, 0, W'(k), 8'hEE, 1);
      if (k >= 1) chk("t6_gnt0", gnt0, 1);
      chk("t6_gnt1", gnt1, 0);
      tick();
    end

    // random traffic, pending requests mostly held until accepted
    p0 = 0; p1 = 0; d0 = 0; d1 = 0;
    m_x0 = 0; m_x1 = 0;
    for (int ph = 0; ph < 4; ph++) begin
      pq = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 100 : 30;
      pr = (ph == 0) ? 100 : (ph == 1) ? 50 : (ph == 2) ? 80 : 90;
      for (int c = 0; c < 500; c++) begin
        if (m_x0 || !p0) begin
          p0 = ($urandom % 100) < pq;
          d0 = W'($urandom);
        end else if ($urandom % 32 == 0) begin
          p0 = 0;
        end
        if (m_x1 || !p1) begin
          p1 = ($urandom % 100) < pq;
          d1 = W'($urandom);
        end else if ($urandom % 32 == 0) begin
          p1 = 0;
        end
        drive($urandom % 200 == 0, p0, p1, d0, d1,
              ($urandom % 100) < pr);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
